// File: rtl/dec_pkg.sv
// Shared constants and types for the 5-bit code to 20-bit one-hot receive path.
package dec_pkg;

  localparam int NUM_OUT = 20;
  localparam int CODE_W  = 5;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [NUM_OUT-1:0] onehot_t;

  // Codes outside 0..NUM_OUT-1 map to an all-zero word.
  function automatic onehot_t to_onehot(input code_t code);
    onehot_t oh;
    oh = '0;
    if ({1'b0, code} < (CODE_W + 1)'(NUM_OUT)) begin
      oh[code] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/dec5to20_strobe_fifo.sv
// Small synchronous FIFO holding decoded codes. A push and a pop in the same
// cycle are accepted even when full, because the pop frees the slot first.
module code_fifo
  import dec_pkg::*;
#(
  parameter int WIDTH = CODE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful while occupancy covers them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/dec5to20_strobe.sv
// Receive side of the 20-to-5 encoder link: synchronises code+strobe, turns each
// strobe rising edge into one event, range-checks the code, queues valid codes
// and presents the queue head as a one-hot word with valid/ready.
module dec5to20_strobe #(
  parameter int NUM_OUT     = dec_pkg::NUM_OUT,
  parameter int CODE_W      = dec_pkg::CODE_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               strobe_in,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] onehot_out,
  output logic               out_valid,
  output logic               err_code,
  output logic               overflow,
  output logic [CNT_W-1:0]   event_cnt
);

  // Extra bit so the range check also works when NUM_OUT == 2**CODE_W.
  localparam logic [CODE_W:0]    CODE_LIMIT = (CODE_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] ONEHOT_LSB = NUM_OUT'(1);

  logic [SYNC_STAGES-1:0] strb_sync_q;
  logic [CODE_W-1:0]      code_sync_q [SYNC_STAGES];
  logic                   strb_prev_q;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   strb_s;
  logic [CODE_W-1:0]      code_s;
  logic                   evt, code_bad, pop, push;
  logic                   fifo_full, fifo_empty;
  logic [CODE_W-1:0]      fifo_head;

  // Code travels through the same number of stages as the strobe so the two stay aligned.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      strb_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        code_sync_q[i] <= '0;
      end
    end else begin
      strb_sync_q    <= {strb_sync_q[SYNC_STAGES-2:0], strobe_in};
      code_sync_q[0] <= code_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        code_sync_q[i] <= code_sync_q[i-1];
      end
    end
  end

  assign strb_s = strb_sync_q[SYNC_STAGES-1];
  assign code_s = code_sync_q[SYNC_STAGES-1];

  // Event classification: bad code beats overflow beats push; a same-cycle pop makes room.
  always_comb begin
    evt      = strb_s & ~strb_prev_q;
    code_bad = ({1'b0, code_s} >= CODE_LIMIT);
    pop      = ~fifo_empty & out_ready;
    err_d    = evt & code_bad;
    ovf_d    = evt & ~code_bad & fifo_full & ~pop;
    push     = evt & ~code_bad & (~fifo_full | pop);
    cnt_d    = push ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Edge-detect history, one-cycle status pulses and the accepted-event counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      strb_prev_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      strb_prev_q <= strb_s;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (code_s),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Outputs are decoded from registered state only.
  assign out_valid  = ~fifo_empty;
  assign onehot_out = out_valid ? (ONEHOT_LSB << fifo_head) : '0;
  assign err_code   = err_q;
  assign overflow   = ovf_q;
  assign event_cnt  = cnt_q;

endmodule

// File: tb/tb_dec5to20_strobe.sv
// Directed and randomized stimulus for dec5to20_strobe, checked every cycle
// against a queue-based behavioural model of the receive path.
module tb_dec5to20_strobe;

  localparam int NUM_OUT = 20;
  localparam int SYNC    = 2;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  code_in;
  logic        strobe_in;
  logic        out_ready;
  logic [19:0] onehot_out;
  logic        out_valid;
  logic        err_code;
  logic        overflow;
  logic [7:0]  event_cnt;

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_ovf  = 0;

  // Behavioural model state
  bit m_ss[$];
  int m_cs[$];
  bit m_prev;
  int m_fifo[$];
  int m_cnt;
  bit m_err, m_ovf;

  dec5to20_strobe dut (
    .clk        (clk),
    .nrst       (nrst),
    .code_in    (code_in),
    .strobe_in  (strobe_in),
    .out_ready  (out_ready),
    .onehot_out (onehot_out),
    .out_valid  (out_valid),
    .err_code   (err_code),
    .overflow   (overflow),
    .event_cnt  (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare all outputs after it.
  task automatic tick(input bit n, input bit s, input int c, input bit r);
    bit ss, ev, pp, bad;
    int cs;
    logic [31:0] exp_oh;
    nrst      = n;
    strobe_in = s;
    code_in   = 5'(c);
    out_ready = r;
    @(posedge clk);
    if (!n) begin
      m_ss = {};
      m_cs = {};
      for (int i = 0; i < SYNC; i++) begin
        m_ss.push_back(1'b0);
        m_cs.push_back(0);
      end
      m_prev = 1'b0;
      m_fifo = {};
      m_cnt  = 0;
      m_err  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      ss    = m_ss[SYNC-1];
      cs    = m_cs[SYNC-1];
      ev    = ss && !m_prev;
      pp    = (m_fifo.size() > 0) && r;
      bad   = (cs >= NUM_OUT);
      m_err = ev && bad;
      m_ovf = ev && !bad && (m_fifo.size() == DEPTH) && !pp;
      if (pp) void'(m_fifo.pop_front());
      if (ev && !bad && !m_ovf) begin
        m_fifo.push_back(cs);
        m_cnt = (m_cnt + 1) % 256;
      end
      m_prev = ss;
      m_ss.push_front(s);
      void'(m_ss.pop_back());
      m_cs.push_front(c);
      void'(m_cs.pop_back());
    end
    #1;
    if (err_code === 1'b1) n_err++;
    if (overflow === 1'b1) n_ovf++;
    exp_oh = (m_fifo.size() > 0) ? (32'd1 << m_fifo[0]) : 32'd0;
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
    check("onehot_out", 32'(onehot_out), exp_oh);
    check("err_code", 32'(err_code), 32'(m_err));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("event_cnt", 32'(event_cnt), 32'(m_cnt));
  endtask

  initial begin
    // 1: reset with toggling inputs
    tick(0, 1, 7, 1);
    tick(0, 0, 25, 0);
    check("rst_cnt", 32'(event_cnt), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);

    // 2: sweep every valid code with out_ready high
    for (int c = 0; c < 20; c++) begin
      tick(1, 1, c, 1);
      tick(1, 1, c, 1);
      check("sweep_lat_pre", 32'(out_valid), 32'd0);
      tick(1, 0, c, 1);
      check("sweep_oh", 32'(onehot_out), 32'd1 << c);
      tick(1, 0, c, 1);
      check("sweep_drain", 32'(out_valid), 32'd0);
      tick(1, 0, c, 1);
    end
    check("sweep_cnt", 32'(event_cnt), 32'd20);

    // 3: out-of-range codes
    n_err = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1, 1, (k == 0) ? 20 : 31, 1);
      for (int j = 0; j < 4; j++) tick(1, 0, 0, 1);
    end
    check("inv_err_pulses", 32'(n_err), 32'd2);
    check("inv_cnt", 32'(event_cnt), 32'd20);

    // 4: backpressure, fifth event overflows
    n_ovf = 0;
    for (int c = 1; c <= 5; c++) begin
      tick(1, 1, c, 0);
      tick(1, 0, c, 0);
    end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("bp_ovf_pulses", 32'(n_ovf), 32'd1);
    check("bp_head", 32'(onehot_out), 32'h2);
    for (int j = 0; j < 6; j++) tick(1, 0, 0, 1);
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_cnt", 32'(event_cnt), 32'd24);

    // 5: full FIFO with a pop on the edge the fifth event is pushed
    n_ovf = 0;
    for (int c = 1; c <= 4; c++) begin
      tick(1, 1, c, 0);
      tick(1, 0, c, 0);
    end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 1, 5, 0);
    tick(1, 0, 5, 0);
    tick(1, 0, 5, 1);
    check("fp_head", 32'(onehot_out), 32'h4);
    for (int j = 0; j < 6; j++) tick(1, 0, 0, 1);
    check("fp_no_ovf", 32'(n_ovf), 32'd0);
    check("fp_cnt", 32'(event_cnt), 32'd29);

    // 6: reset mid-operation, strobe held high across release
    for (int c = 7; c <= 9; c++) begin
      tick(1, 1, c, 0);
      tick(1, 0, c, 0);
    end
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 3, 0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(event_cnt), 32'd0);
    for (int j = 0; j < 8; j++) tick(1, 1, 3, 1);
    check("mid_rst_one_evt", 32'(event_cnt), 32'd1);

    // Randomized traffic against the model
    for (int j = 0; j < 800; j++) begin
      int c;
      c = (($urandom % 4) == 0) ? int'($urandom_range(31, 20)) : int'($urandom_range(19, 0));
      tick((($urandom % 128) != 0), (($urandom % 3) != 0), c, (($urandom % 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
